calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Instruction sequencer and ALU for the queue calculator; the sole driver of `queue_with_controller`'s `opcode`/`back` inputs and the consumer of its `top_conc`. It accepts instruction tokens over a valid/ready handshake and turns each one into a single queue command. For compute instructions, it evaluates the front operand pair with add, sub, multi-cycle mul, or multi-cycle div before issuing the command.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width; must match queue cell width.
- `DEPTH`, 5: queue capacity, used by the shadow occupancy counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  instruction token valid.
- `in_ready`  out  1  sequencer can accept a token this cycle.
- `in_kind`  in  2  token kind: 00 push, 01 compute, 10 pop, 11 nop.
- `in_aluop`  in  2  compute op: 00 add, 01 sub, 10 mul, 11 div.
- `in_data`  in  WIDTH  push value.
- `q_opcode`  out  2  to queue `opcode`: 00 push, 10 replace-pair, 11 pop front, 01 idle.
- `q_back`  out  WIDTH  to queue `back`.
- `q_top_conc`  in  2*WIDTH  from queue: {front, second}.
- `q_is_err`  in  1  queue sticky error.
- `result_valid`  out  1  one-cycle pulse when a compute result is issued.
- `result`  out  WIDTH  last computed result; held between pulses.
- `err`  out  1  sticky error.
- `err_code`  out  2  00 queue fault, 01 overflow, 10 underflow, 11 divide by zero.

## Operation
- **Handshake.** A token is accepted when `in_valid && in_ready`. `in_ready` = (state == IDLE) && !err.
- **States.**
  - IDLE: accepting tokens.
  - EXEC: mul/div iterations.
  - ISSUE: drives one queue command for exactly one cycle, then returns to IDLE.
  - HALT: entered on error.
- **Shadow count.** `cnt`, range 0..DEPTH, mirrors queue occupancy. The sequencer is the only queue driver, and both blocks share `rst`.
- **push.**
  - If `cnt == DEPTH`: overflow error; no command is issued.
  - Otherwise: ISSUE with `q_opcode=00`, `q_back=in_data`, and `cnt+1`.
- **pop.**
  - If `cnt == 0`: underflow error.
  - Otherwise: ISSUE with `q_opcode=11` and `cnt-1`.
- **compute.**
  - If `cnt < 2`: underflow error.
  - Otherwise, latch `a = q_top_conc[2W-1:W]` (front) and `b = q_top_conc[W-1:0]` in the accept cycle.
- **compute arithmetic**, all modulo 2^WIDTH:
  - add: `a+b`.
  - sub: `a-b`.
  - mul: low WIDTH bits of `a*b`, computed by shift-add, one bit per cycle.
  - div: `floor(a/b)` by restoring division, one quotient bit per cycle.
  - div with `b == 0`: divide-by-zero error detected in the accept cycle; no command is issued.
- **compute issue.** ISSUE with `q_opcode=10`, `q_back=result`, `cnt-1`, and `result_valid=1`; `result` is updated.
- **nop.** Accepted; no command, no state change; stays in IDLE.
- **Errors.**
  - An error sets `err=1` and `err_code`, and moves to HALT. `q_opcode` stays 01 until `rst`.
  - If `q_is_err` is sampled high in any state, the result is HALT with code 00. This applies unless an own error is set in the same cycle, in which case the own code wins.
- **Idle command.** Outside ISSUE, `q_opcode=01` and `q_back=0`.

## Timing
- **Reset values:**
  - state IDLE, `cnt=0`.
  - `q_opcode=01`, `q_back=0`.
  - `result=0`, `result_valid=0`.
  - `err=0`, `err_code=00`.
  - `in_ready` is 1 in the first cycle after `rst` deasserts.
- **Latencies**, with the token accepted in cycle T:
  - push/pop and add/sub: ISSUE in T+1, `in_ready` high again at T+2.
  - mul/div: EXEC for T+1..T+WIDTH, ISSUE in T+WIDTH+1.
- **Operand sampling.** The queue updates on the edge ending ISSUE, so `q_top_conc` sampled in IDLE is always current.
- **Error timing.** For a token accepted at T with an error, `err` is high from T+1.
- **Reset mid-operation.** `rst` during EXEC or ISSUE aborts; no command is issued after the `rst` edge.

## Test plan
- **Push and add.** Reset, push 5, push 7, compute add → one ISSUE with `q_opcode=10`, `q_back=12`, `result_valid` pulse. Queue front is 12 and `cnt=1`.
- **Sub wrap and latency.** Push 3, push 5, compute sub → `result=0xFE`; ISSUE exactly 1 cycle after accept.
- **Multi-cycle ops.**
  - Push 12, push 11, mul → `result=0x84`, ISSUE at accept+9, `in_ready` low for cycles 1..9.
  - Push 200, push 7, div → `result=28`.
- **Divide by zero.** Push 9, push 0, div → `err=1`, `err_code=11`. No `q_opcode=10` is ever driven, and `in_ready` stays 0 until `rst`.
- **Overflow and underflow.**
  - Six pushes → the sixth gives `err_code=01`, and the queue holds the first five values.
  - After reset, pop → `err_code=10`.
  - After reset, push 1 then compute → `err_code=10`.
- **Nop, queue fault, reset mid-op.**
  - nop between pushes → no command, no `cnt` change.
  - Force `q_is_err=1` → HALT with `err_code=00`.
  - `rst` during mul EXEC → returns to reset values, no ISSUE.

Source files
------------

// File: rtl/calc_sequencer.sv
// Queue calculator sequencer: turns instruction tokens into single queue commands,
// evaluating add/sub in one cycle and mul/div iteratively (one bit per cycle).
module calc_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_kind,
  input  logic [1:0]         in_aluop,
  input  logic [WIDTH-1:0]   in_data,
  output logic [1:0]         q_opcode,
  output logic [WIDTH-1:0]   q_back,
  input  logic [2*WIDTH-1:0] q_top_conc,
  input  logic               q_is_err,
  output logic               result_valid,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic [1:0]         err_code
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(WIDTH + 1);

  localparam logic [1:0] K_PUSH = 2'b00, K_COMP = 2'b01, K_POP = 2'b10, K_NOP = 2'b11;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam logic [1:0] Q_PUSH = 2'b00, Q_IDLE = 2'b01, Q_REPL = 2'b10, Q_POP = 2'b11;
  localparam logic [1:0] E_QUEUE = 2'b00, E_OVF = 2'b01, E_UNF = 2'b10, E_DIV0 = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ISSUE, S_HALT} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_iter;
  logic [1:0]       r_cmd_op;
  logic [WIDTH-1:0] r_cmd_back;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_rem, r_result;
  logic             r_div, r_err;
  logic [1:0]       r_err_code;

  logic             w_accept, w_own_err, w_last;
  logic [1:0]       w_own_code;
  logic [WIDTH-1:0] w_front, w_second, w_acc_next, w_rem_next, w_quo_next;
  logic [WIDTH:0]   w_rem_sh, w_rem_diff;
  logic             w_fits;

  assign w_front  = q_top_conc[2*WIDTH-1:WIDTH];
  assign w_second = q_top_conc[WIDTH-1:0];
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_iter == IW'(WIDTH - 1));

  // Shift-add step: r_a is the shifting multiplicand, r_b the shifting multiplier.
  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

  // Restoring division step: r_a shifts dividend bits out and quotient bits in.
  assign w_rem_sh   = {r_rem, r_a[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_b};
  assign w_fits     = !w_rem_diff[WIDTH];
  assign w_rem_next = w_fits ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_a[WIDTH-2:0], w_fits};

  always_comb begin
    w_own_err  = 1'b0;
    w_own_code = E_QUEUE;
    if (w_accept) begin
      unique case (in_kind)
        K_PUSH: if (r_cnt == CW'(DEPTH)) begin w_own_err = 1'b1; w_own_code = E_OVF; end
        K_POP:  if (r_cnt == '0) begin w_own_err = 1'b1; w_own_code = E_UNF; end
        K_COMP: begin
          if (r_cnt < CW'(2)) begin
            w_own_err = 1'b1; w_own_code = E_UNF;
          end else if (in_aluop == OP_DIV && w_second == '0) begin
            w_own_err = 1'b1; w_own_code = E_DIV0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_own_err)                             w_next = S_HALT;
        else if (in_kind == K_NOP)                 w_next = S_IDLE;
        else if (in_kind == K_COMP && in_aluop[1]) w_next = S_EXEC;
        else                                       w_next = S_ISSUE;
      end
      S_EXEC:  if (w_last) w_next = S_ISSUE;
      S_ISSUE: w_next = S_IDLE;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
    if (q_is_err) w_next = S_HALT;
  end

  always_comb begin
    in_ready     = (r_state == S_IDLE) && !r_err;
    q_opcode     = Q_IDLE;
    q_back       = '0;
    result_valid = 1'b0;
    if (r_state == S_ISSUE) begin
      q_opcode     = r_cmd_op;
      q_back       = (r_cmd_op == Q_REPL) ? r_result : (r_cmd_op == Q_PUSH) ? r_cmd_back : '0;
      result_valid = (r_cmd_op == Q_REPL);
    end
  end

  assign result   = r_result;
  assign err      = r_err;
  assign err_code = r_err_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0; r_iter <= '0; r_cmd_op <= Q_IDLE; r_cmd_back <= '0;
      r_a <= '0; r_b <= '0; r_acc <= '0; r_rem <= '0; r_result <= '0;
      r_div <= 1'b0; r_err <= 1'b0; r_err_code <= E_QUEUE;
    end else begin
      if (!r_err && (w_own_err || q_is_err)) begin
        r_err      <= 1'b1;
        r_err_code <= w_own_err ? w_own_code : E_QUEUE;
      end
      if (w_accept) begin
        r_cmd_op   <= (in_kind == K_PUSH) ? Q_PUSH : (in_kind == K_POP) ? Q_POP : Q_REPL;
        r_cmd_back <= in_data;
        r_a        <= w_front;
        r_b        <= w_second;
        r_acc      <= '0;
        r_rem      <= '0;
        r_iter     <= '0;
        r_div      <= in_aluop[0];
        if (in_kind == K_COMP && !in_aluop[1] && !w_own_err)
          r_result <= in_aluop[0] ? (w_front - w_second) : (w_front + w_second);
      end
      if (r_state == S_EXEC) begin
        r_iter <= r_iter + 1'b1;
        if (r_div) begin
          r_rem <= w_rem_next;
          r_a   <= w_quo_next;
        end else begin
          r_acc <= w_acc_next;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
        end
        if (w_last) r_result <= r_div ? w_quo_next : w_acc_next;
      end
      // Occupancy follows the queue, which applies the command on the edge ending ISSUE.
      if (r_state == S_ISSUE) begin
        if (r_cmd_op == Q_PUSH) r_cnt <= r_cnt + 1'b1;
        else                    r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural model of the driven queue.
module tb_calc_sequencer;
  localparam int W = 8;

  logic           clk = 1'b0, rst = 1'b1, in_valid = 1'b0, q_is_err = 1'b0;
  logic [1:0]     in_kind = '0, in_aluop = '0;
  logic [W-1:0]   in_data = '0;
  logic [2*W-1:0] q_top_conc = '0;
  logic           in_ready, result_valid, err;
  logic [1:0]     q_opcode, err_code;
  logic [W-1:0]   q_back, result;

  calc_sequencer #(.WIDTH(W), .DEPTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_aluop(in_aluop), .in_data(in_data),
    .q_opcode(q_opcode), .q_back(q_back), .q_top_conc(q_top_conc), .q_is_err(q_is_err),
    .result_valid(result_valid), .result(result), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue model and command monitor; everything here clears while rst is high.
  logic [W-1:0] mq[$];
  logic [1:0]   last_op = 2'b01;
  logic [W-1:0] last_back = '0, f0, f1;
  int cyc = 0, acc_cyc = 0, iss_cyc = 0, n_cmd = 0, n_repl = 0, n_rv = 0, run = 0, last_run = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      n_cmd = 0; n_repl = 0; n_rv = 0; run = 0; last_run = 0; acc_cyc = 0; iss_cyc = 0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (!in_ready) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      if (result_valid) n_rv++;
      if (q_opcode != 2'b01) begin
        n_cmd++; iss_cyc = cyc; last_op = q_opcode; last_back = q_back;
        case (q_opcode)
          2'b00: mq.push_back(q_back);
          2'b11: if (mq.size() > 0) void'(mq.pop_front());
          2'b10: begin
            n_repl++;
            if (mq.size() > 0) void'(mq.pop_front());
            if (mq.size() > 0) mq[0] = q_back;
          end
          default: ;
        endcase
      end
    end
    f0 = '0; f1 = '0;
    if (mq.size() > 0) f0 = mq[0];
    if (mq.size() > 1) f1 = mq[1];
    q_top_conc = {f0, f1};
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; q_is_err = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] k, input logic [1:0] op, input logic [W-1:0] d);
    int t;
    t = 0;
    step();
    while (!in_ready && t < 40) begin step(); t++; end
    check("ready_before_send", in_ready, 1);
    in_valid = 1'b1; in_kind = k; in_aluop = op; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(in_ready || err) && t < 40) begin step(); t++; end
    if (t >= 40) check("idle_timeout", in_ready | err, 1);
    @(negedge clk); #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    send(2'b00, 2'b00, d); wait_idle();
  endtask

  logic [W-1:0] va[8]  = '{8'd5, 8'd3, 8'd12, 8'd200, 8'd255, 8'd255, 8'd200, 8'd7};
  logic [W-1:0] vb[8]  = '{8'd7, 8'd5, 8'd11, 8'd7,   8'd255, 8'd1,   8'd100, 8'd200};
  logic [1:0]   vop[8] = '{2'd0, 2'd1, 2'd2,  2'd3,   2'd2,   2'd3,   2'd0,   2'd3};
  logic [W-1:0] vexp[8] = '{8'd12, 8'hFE, 8'h84, 8'd28, 8'h01, 8'hFF, 8'h2C, 8'd0};
  int           vlat[8] = '{1, 1, 9, 9, 9, 9, 1, 9};

  initial begin
    logic [W-1:0] e0, e4;
    do_reset();
    check("rst_q_opcode", q_opcode, 2'b01);
    check("rst_q_back", q_back, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_in_ready", in_ready, 1);

    push(8'd5);
    check("push_op", last_op, 2'b00);
    check("push_back", last_back, 8'd5);
    check("push_lat", iss_cyc - acc_cyc, 1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      push(va[i]); push(vb[i]);
      send(2'b01, vop[i], '0); wait_idle();
      check("cmp_result", result, vexp[i]);
      check("cmp_op", last_op, 2'b10);
      check("cmp_back", last_back, vexp[i]);
      check("cmp_latency", iss_cyc - acc_cyc, vlat[i]);
      check("cmp_ready_low", last_run, vlat[i]);
      check("cmp_rv_pulses", n_rv, 1);
      check("cmp_qsize", mq.size(), 1);
      check("cmp_front", q_top_conc[2*W-1:W], vexp[i]);
      check("cmp_err", err, 0);
    end

    do_reset();
    push(8'd9); push(8'd0);
    send(2'b01, 2'b11, '0);
    @(negedge clk); #1;
    check("div0_err", err, 1);
    check("div0_code", err_code, 2'b11);
    repeat (6) step();
    check("div0_ready", in_ready, 0);
    check("div0_no_repl", n_repl, 0);
    check("div0_cmds", n_cmd, 2);

    do_reset();
    for (int i = 1; i <= 5; i++) push(W'(i));
    send(2'b00, 2'b00, 8'd6);
    @(negedge clk); #1;
    repeat (3) step();
    e0 = mq[0]; e4 = mq[4];
    check("ovf_err", err, 1);
    check("ovf_code", err_code, 2'b01);
    check("ovf_cmds", n_cmd, 5);
    check("ovf_qsize", mq.size(), 5);
    check("ovf_first", e0, 8'd1);
    check("ovf_last", e4, 8'd5);

    do_reset();
    send(2'b10, 2'b00, '0);
    @(negedge clk); #1;
    check("pop_unf_err", err, 1);
    check("pop_unf_code", err_code, 2'b10);
    check("pop_unf_cmds", n_cmd, 0);

    do_reset();
    push(8'd1);
    send(2'b01, 2'b00, '0);
    @(negedge clk); #1;
    check("cmp_unf_code", err_code, 2'b10);
    check("cmp_unf_no_repl", n_repl, 0);

    do_reset();
    push(8'd4);
    send(2'b11, 2'b00, '0); wait_idle();
    check("nop_cmds", n_cmd, 1);
    check("nop_ready", in_ready, 1);
    send(2'b10, 2'b00, '0); wait_idle();
    check("nop_pop_op", last_op, 2'b11);
    send(2'b10, 2'b00, '0);
    @(negedge clk); #1;
    check("nop_cnt_unf", err_code, 2'b10);
    check("nop_cnt_cmds", n_cmd, 2);

    do_reset();
    push(8'd8);
    q_is_err = 1'b1;
    step();
    q_is_err = 1'b0;
    @(negedge clk); #1;
    check("qerr_err", err, 1);
    check("qerr_code", err_code, 2'b00);
    check("qerr_ready", in_ready, 0);

    do_reset();
    push(8'd2); push(8'd3);
    send(2'b01, 2'b10, '0);
    repeat (3) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("midrst_ready", in_ready, 1);
    check("midrst_opcode", q_opcode, 2'b01);
    check("midrst_result", result, 0);
    check("midrst_err", err, 0);
    repeat (15) step();
    check("midrst_no_issue", n_cmd, 0);
    check("midrst_no_rv", n_rv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
